a2d_intf: RTL and testbench
===========================

Name: a2d_intf

Overview:
- SPI master that periodically reads the off-board 12-bit A2D (ADC128S-compatible slave) over SS_n/SCLK/MOSI/MISO.
- Round-robins channels 0 (battery), 1 (current) and 4 (torque), and holds the latest result for each in a register for the sensor/PID logic.
- Each conversion takes two back-to-back 16-bit transactions, because the slave returns the result for the channel requested in the previous frame.

Parameters:
- CONV_TMR_W, 14, width of the free-running conversion timer; one conversion is launched per 2^CONV_TMR_W clks.
- GAP_CLKS, 32, clks SS_n stays high between the command and read transactions.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- MISO  input  1  serial data from A2D
- SS_n  output  1  active-low slave select
- SCLK  output  1  serial clock, clk/32, idles high
- MOSI  output  1  serial data to A2D
- batt  output  12  latest channel-0 result
- curr  output  12  latest channel-1 result
- torque  output  12  latest channel-4 result
- cnv_cmplt  output  1  one-clk pulse when a result register updates

Behaviour:
- Reset values: SS_n=1, SCLK=1, MOSI=0, batt/curr/torque=12'h000, cnv_cmplt=0, timer=0, channel pointer=0, FSM=IDLE.
- Reset mid-transaction aborts at once to these values; no partial result is written.
- Timer: free-running up-counter of width CONV_TMR_W. A conversion starts when the timer is all-ones and the FSM is in IDLE.
  - The first conversion starts 2^CONV_TMR_W clks after reset.
  - A timer wrap while the FSM is not in IDLE is ignored; no conversion is queued.
- SPI engine (mode 3, MSB first):
  - 5-bit sclk_div; SCLK = sclk_div[4].
  - On transaction start, SS_n drops and sclk_div is preloaded to 5'b10111 (8-clk front porch).
  - sclk_div increments each clk while active.
  - MISO is sampled into a holding flop when sclk_div transitions 01111->10000 (SCLK rise).
  - The 16-bit shift register shifts left, inserting the sampled bit, at 11111 (SCLK fall).
  - MOSI = shift[15]. The command is loaded at start.
  - After the 16th sample, at the next sclk_div==11111:
    - the final shift occurs;
    - SCLK is held high and SS_n rises;
    - an internal done pulses.
  - SS_n is low for 520 clks per transaction; exactly 16 SCLK falling and 16 rising edges occur.
- Command word: {2'b00, ch[2:0], 11'h000}, where ch is the current pointer channel. Both transactions of a conversion send the same word.
- FSM:
  - IDLE: on start -> CMD (launch transaction).
  - CMD: on done -> GAP (SS_n high, count GAP_CLKS).
  - GAP: on count expiry -> READ (launch transaction).
  - READ: on done -> capture shift[11:0] into the register for ch, pulse cnv_cmplt for 1 clk, advance the pointer 0->1->4->0, -> IDLE.
  - Data received during CMD is discarded.
- cnv_cmplt asserts in the same clk the result register updates. The other two result registers hold.
- SCLK never toggles while SS_n is high. MOSI is stable while SCLK is rising.

Test Plan:
- Reset, run with the ADC128S model attached -> outputs at reset values; SS_n stays high until clk 16384; first SS_n fall at 16384 (±1).
- Probe the first transaction -> SS_n low 520 clks, 16 SCLK rising edges, SCLK period 32 clks, MOSI bits = 16'h0000.
- Run 4 conversions against the model -> batt=12'hC00 after the 1st cnv_cmplt, curr=12'hBF1 after the 2nd, torque=12'hBE4 after the 3rd, batt=12'hBD0 after the 4th; the unaffected registers hold.
- Check MOSI on the 2nd and 3rd conversions -> both frames equal 16'h0800 (ch1) and 16'h2000 (ch4) respectively; SS_n high gap between frames = 32 clks.
- Assert rst_n low midway through a READ frame -> SS_n=1 and SCLK=1 immediately, result registers return to 0, no cnv_cmplt. After release, the next conversion uses channel 0 and batt updates normally.
- Run a long simulation -> exactly one cnv_cmplt per 16384 clks, and no SCLK edges while SS_n=1.

Source files
------------

// File: rtl/a2d_intf.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_intf
//  Purpose  : SPI master (mode 3, MSB first) that periodically reads an
//             ADC128S-compatible 12-bit A2D. Channels 0 (battery),
//             1 (current) and 4 (torque) are read in round-robin order. The
//             latest result for each channel is held in its own register.
//             Each conversion is two 16-bit frames. The slave answers for the
//             channel named in the previous frame, so the first (command)
//             frame's data is thrown away.
//  Ports    : clk        - system clock
//             rst_n      - asynchronous active-low reset
//             MISO       - serial data from the A2D
//             SS_n       - active-low slave select
//             SCLK       - serial clock (clk/32), idles high
//             MOSI       - serial data to the A2D
//             batt       - latest channel-0 result
//             curr       - latest channel-1 result
//             torque     - latest channel-4 result
//             cnv_cmplt  - one-clk pulse when a result register updates
//  Revision : 1.0  initial release
// ============================================================================
module a2d_intf #(
  parameter int CONV_TMR_W = 14,
  parameter int GAP_CLKS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  localparam int                 C_GAP_W    = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
  // The gap counter stops two short of GAP_CLKS. The launch clk and the
  // front-porch clk before SS_n falls make up the rest of the SS_n-high time.
  localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(GAP_CLKS - 2);
  localparam logic [4:0]         C_DIV_LOAD = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    GAP  = 2'd2,
    READ = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CONV_TMR_W-1:0] tmr_q;
  logic [C_GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [2:0]            ch_q, ch_d;

  logic                  active_q;
  logic                  ss_n_q;
  logic [4:0]            sclk_div_q;
  logic [15:0]           shift_q;
  logic                  miso_smpl_q;
  logic [4:0]            smpl_cnt_q;

  logic [11:0]           batt_q, curr_q, torque_q;
  logic                  cnv_cmplt_q;

  logic                  w_start;
  logic                  w_launch;
  logic                  w_capture;
  logic                  w_smpl;
  logic                  w_fall;
  logic                  w_shift;
  logic                  w_done;
  logic [15:0]           w_cmd;
  logic [11:0]           w_result;

  // --------------------------------------------------------------------------
  // Conversion timer: one launch per wrap, but only when the FSM is idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_q + 1'b1;
  end

  assign w_start = (&tmr_q) && (state_q == IDLE);

  // --------------------------------------------------------------------------
  // SPI engine
  // --------------------------------------------------------------------------
  assign w_cmd   = {2'b00, ch_q, 11'h000};
  assign w_smpl  = active_q && (sclk_div_q == 5'b01111);
  assign w_fall  = active_q && (sclk_div_q == 5'b11111);
  // The first 11111 ends the front porch. Nothing has been sampled yet, so
  // there is no shift there.
  assign w_shift = w_fall && (smpl_cnt_q != 5'd0);
  assign w_done  = w_fall && (smpl_cnt_q == 5'd16);
  // Final shift result, taken in the same clk as the last shift.
  assign w_result = {shift_q[10:0], miso_smpl_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      ss_n_q      <= 1'b1;
      sclk_div_q  <= C_DIV_LOAD;
      shift_q     <= '0;
      miso_smpl_q <= 1'b0;
      smpl_cnt_q  <= '0;
    end else begin
      if (w_launch) begin
        active_q   <= 1'b1;
        sclk_div_q <= C_DIV_LOAD;
        shift_q    <= w_cmd;
        smpl_cnt_q <= '0;
      end else if (active_q) begin
        sclk_div_q <= sclk_div_q + 5'd1;
        if (w_smpl) begin
          miso_smpl_q <= MISO;
          smpl_cnt_q  <= smpl_cnt_q + 5'd1;
        end
        if (w_shift) shift_q <= {shift_q[14:0], miso_smpl_q};
        if (w_done) begin
          active_q   <= 1'b0;
          // Reload rather than wrap so SCLK stays high after the frame.
          sclk_div_q <= C_DIV_LOAD;
        end
      end

      // SS_n falls one clk after launch, which gives an 8-clk front porch
      // and 520 clks of SS_n low per frame.
      if (w_done)        ss_n_q <= 1'b1;
      else if (active_q) ss_n_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Conversion sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      ch_q      <= 3'd0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      ch_q      <= ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = '0;
    ch_d      = ch_q;
    w_launch  = 1'b0;
    w_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_start) begin
          w_launch = 1'b1;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (w_done) state_d = GAP;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == C_GAP_LAST) begin
          w_launch = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        if (w_done) begin
          w_capture = 1'b1;
          state_d   = IDLE;
          unique case (ch_q)
            3'd0:    ch_d = 3'd1;
            3'd1:    ch_d = 3'd4;
            default: ch_d = 3'd0;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_q      <= '0;
      curr_q      <= '0;
      torque_q    <= '0;
      cnv_cmplt_q <= 1'b0;
    end else begin
      cnv_cmplt_q <= w_capture;
      if (w_capture) begin
        unique case (ch_q)
          3'd0:    batt_q   <= w_result;
          3'd1:    curr_q   <= w_result;
          default: torque_q <= w_result;
        endcase
      end
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_div_q[4];
  assign MOSI      = shift_q[15];
  assign batt      = batt_q;
  assign curr      = curr_q;
  assign torque    = torque_q;
  assign cnv_cmplt = cnv_cmplt_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_intf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a2d_intf
//  Purpose  : Self-checking bench for a2d_intf. Contains an ADC128S-style
//             slave model and a frame-level reference model of the master.
//             The conversion period is shortened to keep the run short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_a2d_intf;

  localparam int TMR_W  = 12;
  localparam int PERIOD = 1 << TMR_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, cnv_cmplt;
  logic [11:0] batt, curr, torque;

  always #5 clk = ~clk;

  a2d_intf #(.CONV_TMR_W(TMR_W), .GAP_CLKS(32)) dut (
    .clk(clk), .rst_n(rst_n), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK),
    .MOSI(MOSI), .batt(batt), .curr(curr), .torque(torque),
    .cnv_cmplt(cnv_cmplt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // ADC128S-style slave. Frame f returns 0xC00 - 0x10*(f/2) + ch, where ch is
  // the channel named in the previous complete frame. The top nibble is
  // random filler that the master has to ignore.
  // --------------------------------------------------------------------------
  int          s_frame = 0;
  int          s_bits = 0;
  logic [2:0]  s_prev_ch = 3'd0;
  logic [15:0] s_tx = '0, s_rx = '0, s_last_rx = '0;
  logic [11:0] s_val = '0, s_last_val = '0;

  always @(negedge SS_n) begin
    s_val = 12'hC00 - 12'(16 * (s_frame / 2)) + {9'd0, s_prev_ch};
    s_tx  = {4'($urandom), s_val};
    s_rx  = '0;
    s_bits = 0;
    s_frame++;
  end

  always @(negedge SCLK) if (SS_n === 1'b0) begin
    MISO = s_tx[15];
    s_tx = {s_tx[14:0], 1'b0};
  end

  always @(posedge SCLK) if (SS_n === 1'b0) begin
    s_rx = {s_rx[14:0], MOSI};
    s_bits++;
  end

  always @(posedge SS_n) begin
    s_last_rx  = s_rx;
    s_last_val = s_val;
    if (s_bits == 16) s_prev_ch = s_rx[13:11];
  end

  // --------------------------------------------------------------------------
  // Frame-level reference model plus a per-cycle compare
  // --------------------------------------------------------------------------
  function automatic logic [2:0] chan(input int idx);
    return (idx == 0) ? 3'd0 : (idx == 1) ? 3'd1 : 3'd4;
  endfunction

  logic        prev_ss, prev_sclk;
  int          low_cnt, high_cnt, rises, falls, cyc, last_cmplt_cyc, ptr_idx;
  bit          in_read, first_fall_pending, exp_cmplt;
  int          n_cmplt = 0;
  logic [11:0] m_batt, m_curr, m_torque;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss = 1'b1; prev_sclk = 1'b1;
      low_cnt = 0; high_cnt = 0; rises = 0; falls = 0; cyc = 0;
      last_cmplt_cyc = -1; ptr_idx = 0; in_read = 0; first_fall_pending = 1;
      m_batt = '0; m_curr = '0; m_torque = '0;
    end else begin
      cyc++;
      exp_cmplt = 0;
      if (prev_ss === 1'b1 && SS_n === 1'b0) begin
        if (first_fall_pending) begin
          checks++;
          if (cyc < PERIOD - 1 || cyc > PERIOD + 1) begin
            errors++;
            $display("FAIL first_fall_clk: got %0d, expected %0d+-1", cyc, PERIOD);
          end
          first_fall_pending = 0;
        end
        if (in_read) chk("gap_clks", high_cnt, 32);
        low_cnt = 0; rises = 0; falls = 0;
      end
      if (SS_n === 1'b0) begin
        low_cnt++;
        if (prev_sclk === 1'b0 && SCLK === 1'b1) rises++;
        if (prev_sclk === 1'b1 && SCLK === 1'b0) falls++;
      end else begin
        chk("sclk_high_while_ss_high", SCLK, 1);
      end
      if (prev_ss === 1'b0 && SS_n === 1'b1) begin
        chk("ss_low_clks", low_cnt, 520);
        chk("sclk_rises", rises, 16);
        chk("sclk_falls", falls, 16);
        chk("mosi_word", s_last_rx, {2'b00, chan(ptr_idx), 11'h000});
        if (in_read) begin
          case (chan(ptr_idx))
            3'd0:    m_batt   = s_last_val;
            3'd1:    m_curr   = s_last_val;
            default: m_torque = s_last_val;
          endcase
          exp_cmplt = 1;
          if (last_cmplt_cyc >= 0) chk("cmplt_period", cyc - last_cmplt_cyc, PERIOD);
          last_cmplt_cyc = cyc;
          ptr_idx = (ptr_idx + 1) % 3;
          in_read = 0;
          n_cmplt++;
        end else begin
          in_read = 1;
        end
        high_cnt = 0;
      end
      if (SS_n === 1'b1) high_cnt++;
      chk("cnv_cmplt", cnv_cmplt, exp_cmplt);
      chk("batt", batt, m_batt);
      chk("curr", curr, m_curr);
      chk("torque", torque, m_torque);
      prev_ss = SS_n;
      prev_sclk = SCLK;
    end
  end

  // --------------------------------------------------------------------------
  // Directed sequence with literal expectations
  // --------------------------------------------------------------------------
  task automatic wait_cmplt(input int target);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk); #1;
      if (n_cmplt >= target) return;
    end
    errors++;
    checks++;
    $display("FAIL wait_cmplt: got %0d conversions, expected %0d", n_cmplt, target);
  endtask

  task automatic chk_regs(input string tag, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] t);
    chk({tag, "_batt"}, batt, b);
    chk({tag, "_curr"}, curr, c);
    chk({tag, "_torque"}, torque, t);
  endtask

  initial begin
    int rst_pt;
    bit hit;
    rst_n = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_cmplt", cnv_cmplt, 0);
    chk_regs("rst", 12'h000, 12'h000, 12'h000);
    #2 rst_n = 1'b1;

    wait_cmplt(1); chk_regs("cnv1", 12'hC00, 12'h000, 12'h000);
    wait_cmplt(2); chk_regs("cnv2", 12'hC00, 12'hBF1, 12'h000);
    wait_cmplt(3); chk_regs("cnv3", 12'hC00, 12'hBF1, 12'hBE4);
    wait_cmplt(4); chk_regs("cnv4", 12'hBD0, 12'hBF1, 12'hBE4);

    // Abort the 5th conversion at a random point inside its READ frame.
    rst_pt = $urandom_range(20, 480);
    hit = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk); #1;
      if (in_read && SS_n === 1'b0 && low_cnt == rst_pt) begin
        hit = 1;
        break;
      end
    end
    chk("reached_read_frame", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_sclk", SCLK, 1);
    chk("abort_cmplt", cnv_cmplt, 0);
    chk_regs("abort", 12'h000, 12'h000, 12'h000);
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      chk("abort_hold_cmplt", cnv_cmplt, 0);
      chk("abort_hold_ss_n", SS_n, 1);
    end
    #2 rst_n = 1'b1;

    wait_cmplt(5); chk_regs("post_rst1", 12'hBB0, 12'h000, 12'h000);
    wait_cmplt(6); chk_regs("post_rst2", 12'hBB0, 12'hBA1, 12'h000);
    wait_cmplt(7); chk_regs("post_rst3", 12'hBB0, 12'hBA1, 12'hB94);
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
